// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 strip driver: FSM state encoding and
// default bit timing for a 12 MHz clock (83.3 ns per cycle).
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_t;

  // 12 MHz: T0H 333 ns, T1H 667 ns, bit period 1.25 us, latch gap 83 us
  localparam int unsigned DEF_T0H_CYC   = 4;
  localparam int unsigned DEF_T1H_CYC   = 8;
  localparam int unsigned DEF_BIT_CYC   = 15;
  localparam int unsigned DEF_LATCH_CYC = 1000;

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// One-bit WS2812 waveform generator: a load starts a BIT_CYC-long period whose
// high phase lasts T1H_CYC or T0H_CYC cycles; bit_done marks its final cycle.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYC = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC = DEF_BIT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_bit,
  output logic o_dout,
  output logic o_bit_done
);

  localparam int unsigned CW = cnt_width(BIT_CYC);
  localparam logic [CW-1:0] T0H_W  = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_W  = CW'(T1H_CYC);
  localparam logic [CW-1:0] LAST_W = CW'(BIT_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          r_bit;
  logic          r_active;
  logic          r_dout;
  logic [CW-1:0] w_high_len;
  logic          w_last;

  assign w_high_len = r_bit ? T1H_W : T0H_W;
  assign w_last     = r_active && (r_cnt == LAST_W);
  assign o_bit_done = w_last;
  assign o_dout     = r_dout;

  // dout is registered against the count it will have next cycle, so the
  // serial line comes straight from a flop and never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_bit    <= 1'b0;
      r_active <= 1'b0;
      r_dout   <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_bit    <= i_bit;
      r_active <= 1'b1;
      r_dout   <= 1'b1;
    end else if (r_active) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_dout   <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_dout <= (r_cnt + CW'(1)) < w_high_len;
      end
    end
  end

endmodule

// File: rtl/ws2812_strip_driver.sv
// WS2812 strip driver: pulls LED_COUNT*CHANNELS bytes through a one-byte
// holding buffer, serialises them MSB first with fixed bit timing, then latches.
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned LED_COUNT = 8,
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned T0H_CYC   = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC   = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC   = DEF_BIT_CYC,
  parameter int unsigned LATCH_CYC = DEF_LATCH_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_request,
  output logic       dout,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned TOTAL = LED_COUNT * CHANNELS;
  localparam int unsigned BW    = cnt_width(TOTAL);
  localparam int unsigned LW    = cnt_width(LATCH_CYC);
  localparam logic [BW-1:0] LAST_IDX   = BW'(TOTAL - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [6:0]    r_shift;      // bits of the current byte not yet started
  logic [2:0]    r_bit_idx;
  logic [BW-1:0] r_byte_idx;
  logic [7:0]    r_hold;
  logic          r_hold_full;
  logic          r_req;
  logic [LW-1:0] r_latch_cnt;

  logic       w_enc_dout;
  logic       w_bit_done;
  logic       w_sending;
  logic       w_byte_end;
  logic       w_frame_end;
  logic       w_next_byte;
  logic       w_first_load;
  logic       w_xfer;
  logic       w_load;
  logic       w_load_bit;
  logic       w_latch_last;
  logic [7:0] w_next_shift;

  assign w_sending    = (r_state == ST_HIGH) || (r_state == ST_LOW);
  assign w_byte_end   = w_sending && w_bit_done && (r_bit_idx == 3'd0);
  assign w_frame_end  = w_byte_end && (r_byte_idx == LAST_IDX);
  assign w_next_byte  = w_byte_end && (r_byte_idx != LAST_IDX);
  assign w_latch_last = (r_state == ST_LATCH) && (r_latch_cnt == LATCH_LAST);

  // The request is withdrawn in the last cycle of bit 0 so a byte can never
  // arrive on the same edge that decides between buffer and underrun.
  assign data_request = (r_state == ST_PREFETCH) || (r_req && !w_byte_end);
  assign w_xfer       = data_request && data_valid;
  assign w_first_load = (r_state == ST_PREFETCH) && w_xfer;
  assign w_next_shift = r_hold_full ? r_hold : 8'h00;
  assign w_load       = w_first_load || (w_sending && w_bit_done && !w_frame_end);

  always_comb begin
    w_load_bit = r_shift[6];
    if (w_first_load) begin
      w_load_bit = data_in[7];
    end else if (w_next_byte) begin
      w_load_bit = w_next_shift[7];
    end
  end

  assign dout       = w_enc_dout;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = w_latch_last;
  assign underrun   = w_next_byte && !r_hold_full;

  ws2812_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_encoder (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_bit      (w_load_bit),
    .o_dout     (w_enc_dout),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // HIGH/LOW follow the encoder's line level; a new bit always re-enters HIGH.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        if (w_xfer) begin
          w_state_next = ST_HIGH;
        end
      end
      ST_HIGH, ST_LOW: begin
        if (w_frame_end) begin
          w_state_next = ST_LATCH;
        end else if (w_bit_done) begin
          w_state_next = ST_HIGH;
        end else if (!w_enc_dout) begin
          w_state_next = ST_LOW;
        end
      end
      ST_LATCH: begin
        if (w_latch_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_req       <= 1'b0;
      r_latch_cnt <= '0;
    end else begin
      if (w_first_load) begin
        r_shift    <= data_in[6:0];
        r_bit_idx  <= 3'd7;
        r_byte_idx <= '0;
      end else if (w_next_byte) begin
        r_shift    <= w_next_shift[6:0];
        r_bit_idx  <= 3'd7;
        r_byte_idx <= r_byte_idx + BW'(1);
      end else if (w_sending && w_bit_done && !w_byte_end) begin
        r_shift   <= {r_shift[5:0], 1'b0};
        r_bit_idx <= r_bit_idx - 3'd1;
      end

      // Ask for the following byte from the first cycle of each byte's MSB.
      if (w_first_load) begin
        r_req <= (TOTAL > 1);
      end else if (w_next_byte) begin
        r_req <= ((r_byte_idx + BW'(1)) != LAST_IDX);
      end else if (w_xfer) begin
        r_req <= 1'b0;
      end

      if (w_first_load || w_byte_end) begin
        r_hold_full <= 1'b0;
      end else if (w_sending && w_xfer) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end

      if (r_state == ST_LATCH) begin
        r_latch_cnt <= r_latch_cnt + LW'(1);
      end else begin
        r_latch_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/ws2812_strip_driver.md
WS2812_STRIP_DRIVER -- requirements
Module: ws2812_strip_driver

Interface
REQ-001 Parameter LED_COUNT, default 8: number of LEDs in the chain, >=1.
REQ-002 Parameter CHANNELS, default 3: bytes per LED (3=GRB, 4=GRBW), 1..4.
REQ-003 Parameter T0H_CYC, default 4: high time of a 0 bit, in clk cycles, >=1.
REQ-004 Parameter T1H_CYC, default 8: high time of a 1 bit, in clk cycles, >T0H_CYC.
REQ-005 Parameter BIT_CYC, default 15: total bit period, in clk cycles, >T1H_CYC.
REQ-006 Parameter LATCH_CYC, default 1000: low latch gap after a frame, in clk cycles, >=1.
REQ-007 Port clk  in  1  single clock for all logic.
REQ-008 Port rst  in  1  reset, asynchronous, active-high.
REQ-009 Port start  in  1  frame request, sampled only in IDLE.
REQ-010 Port data_in  in  8  next pixel byte.
REQ-011 Port data_valid  in  1  data_in valid; ignored while data_request=0.
REQ-012 Port data_request  out  1  driver wants next byte; transfer = data_request&&data_valid at a clk edge.
REQ-013 Port dout  out  1  WS2812 serial line.
REQ-014 Port busy  out  1  high from the cycle after accepted start until the latch gap ends.
REQ-015 Port frame_done  out  1  one-cycle pulse on the last latch cycle.
REQ-016 Port underrun  out  1  one-cycle pulse when a byte was substituted by 0x00.

Function
REQ-017 The FSM SHALL have states IDLE, PREFETCH, HIGH, LOW and LATCH.
REQ-018 In IDLE with start=1, the FSM SHALL enter PREFETCH and assert busy and data_request next cycle; in IDLE with start=0, it SHALL remain in IDLE.
REQ-019 PREFETCH SHALL wait without timeout for the first transfer, load the byte into the shift register, and enter HIGH next cycle.
REQ-020 Bits SHALL be sent MSB first: dout=1 for T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles in HIGH, then dout=0 for the remainder of BIT_CYC in LOW.
REQ-021 Frame length SHALL be exactly LED_COUNT*CHANNELS bytes; the byte counter SHALL be sized by $clog2.
REQ-022 For every byte except the last, data_request SHALL rise in the first cycle of bit 7 of the current byte and fall in the cycle after a transfer; the transfer SHALL go into a one-byte holding buffer.
REQ-023 At the end of bit 0 (LSB), the driver SHALL load the holding buffer if full; otherwise it SHALL load 0x00, pulse underrun, and drop data_request.
REQ-024 After the LSB of the last byte, the FSM SHALL enter LATCH, hold dout=0 for LATCH_CYC cycles, pulse frame_done on the final latch cycle, and return to IDLE with busy=0.
REQ-025 start SHALL be ignored while busy=1; if start=1 in the first IDLE cycle, a new frame SHALL begin (back-to-back frames).
REQ-026 Bit timing SHALL have zero jitter: every bit period SHALL be exactly BIT_CYC cycles, including across byte boundaries and underruns.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, dout=0, busy=0, data_request=0, frame_done=0, underrun=0, and clear counters and buffers.
REQ-028 A reset mid-frame SHALL abort without a frame_done pulse; the first frame after reset SHALL start only on a new start in IDLE.

Structure
REQ-029 Shared package ws2812_pkg SHALL hold the state enum and default timing constants (T0H/T1H/BIT/LATCH for 12 MHz).
REQ-030 The per-bit high/low timer SHALL be the sub-module ws2812_bit_encoder (inputs: load, bit; outputs: dout, bit_done).

Verification (LED_COUNT=2, CHANNELS=3, T0H=2, T1H=4, BIT=6, LATCH=20)
REQ-031 Send byte 0xA5 as byte 0: dout high-times SHALL be 4,2,4,2,2,4,2,4, each bit period 6 cycles.
REQ-032 Full frame with 6 bytes supplied promptly: 288 data cycles, then 20 low cycles, one frame_done pulse, busy falls, underrun never pulses.
REQ-033 Withhold byte 3: bytes 0-2 are sent correctly, byte 3 is sent as 0x00 with a single underrun pulse, and the frame still completes in 308 cycles after PREFETCH.
REQ-034 Pulse start while busy: no effect. Hold start high through frame_done: the second frame begins with PREFETCH in the next cycle.
REQ-035 Assert rst during HIGH of byte 2: dout, busy and data_request go low asynchronously, with no frame_done.
REQ-036 data_valid=1 with data_request=0: no byte consumed; the byte order of the following frame is unchanged.
